ao_periph_req_arbiter: RTL and testbench

- Round-robin arbiter that shares the single external always-on peripheral request port (reg_req_t / reg_rsp_t) of x_heep_system between NUM_REQ special-purpose controllers (im2col SPC plus future SPCs).
- Serialises their DMA-configuration register transactions and routes each response back to the requester that issued it.
- Sits between the SPC instances and ext_ao_peripheral_req_i / ext_ao_peripheral_resp_o in the FPGA and ASIC top wrappers.

---
 rtl/ao_arb_pkg.sv | 27 ++
 rtl/ao_periph_req_arbiter_rr_pick.sv | 33 +++
 rtl/ao_periph_req_arbiter.sv | 140 ++++++++++++++
 tb/tb_ao_periph_req_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ao_arb_pkg.sv
// Shared types for the always-on peripheral request arbiter:
// reg bus request/response structs, FSM states, timeout constants.
package ao_arb_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_0A0A;
  localparam int unsigned TIMEOUT_CNT_W = 16;

endpackage

// File: rtl/ao_periph_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin first-one finder.
// Ports: valid_i (request vector), ptr_i (search start),
//        idx_o (first valid index from ptr_i, wrapping), any_o.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W:0] k;

  // Walk ptr, ptr+1, ... mod N; the first hit wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (k >= (IDX_W+1)'(N)) k = k - (IDX_W+1)'(N);
      for (int j = 0; j < N; j++) begin
        if (!any_o && valid_i[j] && k == (IDX_W+1)'(j)) begin
          any_o = 1'b1;
          idx_o = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/ao_periph_req_arbiter.sv
// Round-robin arbiter sharing one always-on peripheral reg port
// between NUM_REQ controllers; responses go back to the owner.
// Ports: clk_i, rst_ni (async, active low), req_i/rsp_o (requester
// side), req_o/rsp_i (bus side), busy_o, grant_idx_o, timeout_o.
// Optional: define AO_ARB_TIMEOUT_EN to abort stalled accesses
// after TIMEOUT_CYCLES busy cycles with an error response.
module ao_periph_req_arbiter
  import ao_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  reg_req_t         req_i [NUM_REQ],
  output reg_rsp_t         rsp_o [NUM_REQ],
  output reg_req_t         req_o,
  input  reg_rsp_t         rsp_i,
  output logic             busy_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             timeout_o
);

  arb_state_e         state_q;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   ptr_nxt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] valid_vec;
  reg_req_t           own_req;
  logic               busy;
  logic               done;
  logic               abort;
  logic               to_hit;
  logic               release_own;

  always_comb begin
    valid_vec = '0;
    own_req   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      valid_vec[k] = req_i[k].valid;
      if (grant_q == IDX_W'(k)) own_req = req_i[k];
    end
  end

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid_i (valid_vec),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign busy    = (state_q == BUSY);
  assign ptr_nxt = (grant_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
  assign done    = busy && own_req.valid && rsp_i.ready;
  // Owner dropping valid mid-transaction: release without a response.
  assign abort   = busy && !own_req.valid;

`ifdef AO_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_CNT_W-1:0] TO_LAST =
    TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_CNT_W-1:0] cnt_q;
  logic [TIMEOUT_CNT_W-1:0] cnt_d;

  // Held at zero in IDLE so the first BUSY cycle counts from 0.
  always_comb begin
    cnt_d = cnt_q;
    if (!busy) cnt_d = '0;
    else if (!rsp_i.ready) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // A real ready in the same cycle takes precedence.
  assign to_hit    = busy && own_req.valid && !rsp_i.ready &&
                     (cnt_q == TO_LAST);
  assign timeout_o = to_hit;
`else
  assign to_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign release_own = done || abort || to_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (release_own) begin
            state_q <= IDLE;
            ptr_q   <= ptr_nxt;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_o = '0;
    if (busy) begin
      req_o = own_req;
      if (to_hit) req_o.valid = 1'b0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      rsp_o[k] = '0;
      if (busy && grant_q == IDX_W'(k)) begin
        rsp_o[k] = rsp_i;
        if (to_hit) begin
          rsp_o[k].ready = 1'b1;
          rsp_o[k].error = 1'b1;
          rsp_o[k].rdata = TIMEOUT_RDATA;
        end
      end
    end
  end

  assign busy_o      = busy;
  assign grant_idx_o = grant_q;

endmodule

// File: tb/tb_ao_periph_req_arbiter.sv
// Scoreboard bench for ao_periph_req_arbiter (3 requesters).
// Directed vectors push expected responses; a monitor checks them.
module tb_ao_periph_req_arbiter;
  import ao_arb_pkg::*;

  localparam int N  = 3;
  localparam int TO = 8;
  localparam int IW = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
    logic        to;
    logic [7:0]  cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  reg_req_t      req_i [N];
  reg_rsp_t      rsp_o [N];
  reg_req_t      req_o;
  reg_rsp_t      rsp_i;
  logic          busy_o;
  logic [IW-1:0] grant_idx_o;
  logic          timeout_o;

  int tests = 0;
  int fails = 0;

  exp_t     exp_q [N][$];
  reg_req_t cmd_q [N][$];
  int       gnt_q [$];
  exp_t     mon_e;
  logic [N-1:0] done;
  int       wait_cnt = 0;
  int       slv_lat = 0;
  int       bcnt = 0;

  always #5 clk = ~clk;

  ao_periph_req_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req_i),
    .rsp_o       (rsp_o),
    .req_o       (req_o),
    .rsp_i       (rsp_i),
    .busy_o      (busy_o),
    .grant_idx_o (grant_idx_o),
    .timeout_o   (timeout_o)
  );

  // Slave: addr[31:16]==FFFF never answers, low half 0BAD errors,
  // reads return addr + 0x1000_0000 after slv_lat wait cycles.
  always_comb begin
    rsp_i = '0;
    if (req_o.valid && req_o.addr[31:16] != 16'hFFFF &&
        wait_cnt >= slv_lat) begin
      rsp_i.ready = 1'b1;
      rsp_i.error = (req_o.addr[15:0] == 16'h0BAD);
      if (!req_o.write) rsp_i.rdata = req_o.addr + 32'h1000_0000;
    end
  end

  always @(posedge clk)
    wait_cnt <= (req_o.valid && !rsp_i.ready) ? wait_cnt + 1 : 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Requesters: hold a command until its ready, then take the next.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        req_i[k] = '0;
        cmd_q[k].delete();
      end else if (!req_i[k].valid || done[k]) begin
        if (cmd_q[k].size() > 0) req_i[k] = cmd_q[k].pop_front();
        else req_i[k] = '0;
      end
    end
  end

  // Monitor: mid low phase, after requester updates have settled.
  always @(negedge clk) begin
    #2;
    done = '0;
    bcnt = busy_o ? bcnt + 1 : 0;
    for (int k = 0; k < N; k++) begin
      done[k] = req_i[k].valid && rsp_o[k].ready;
      if (rsp_o[k].ready) begin
        if (exp_q[k].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexp_rsp%0d: got ready=1 want none", k);
        end else begin
          mon_e = exp_q[k].pop_front();
          chk($sformatf("gnt_idx%0d", k), 32'(grant_idx_o), k);
          if (gnt_q.size() > 0)
            chk("gnt_order", k, gnt_q.pop_front());
          else
            chk("gnt_order_extra", k, 32'hFFFF_FFFF);
          chk($sformatf("rdata%0d", k), rsp_o[k].rdata, mon_e.rdata);
          chk($sformatf("err%0d", k), 32'(rsp_o[k].error), 32'(mon_e.err));
          chk("timeout_o", 32'(timeout_o), 32'(mon_e.to));
          chk("req_o_valid", 32'(req_o.valid), 32'(!mon_e.to));
          if (!mon_e.to) chk("req_o_addr", req_o.addr, mon_e.addr);
          chk($sformatf("cycles%0d", k), bcnt, 32'(mon_e.cyc));
          for (int j = 0; j < N; j++)
            if (j != k)
              chk($sformatf("iso%0d", j), 32'(rsp_o[j] != '0), 0);
        end
      end
    end
  end

  task automatic issue(int k, logic wr, logic [31:0] addr,
                       logic [31:0] wdata, logic [31:0] rdata,
                       logic err, logic to, int cyc, bit has_exp);
    reg_req_t r;
    exp_t     e;
    r       = '0;
    r.valid = 1'b1;
    r.write = wr;
    r.addr  = addr;
    r.wdata = wdata;
    r.wstrb = wr ? 4'hF : 4'h0;
    cmd_q[k].push_back(r);
    if (has_exp) begin
      e.addr  = addr;
      e.rdata = rdata;
      e.err   = err;
      e.to    = to;
      e.cyc   = 8'(cyc);
      exp_q[k].push_back(e);
    end
  endtask

  function automatic int pending();
    int p = 0;
    for (int k = 0; k < N; k++) p += exp_q[k].size() + cmd_q[k].size();
    return p;
  endfunction

  task automatic drain(int budget);
    int c = 0;
    while (c < budget && pending() != 0) begin
      @(posedge clk);
      c++;
    end
    chk("drain_outstanding", pending(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(req_o.valid), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_grant", 32'(grant_idx_o), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    for (int k = 0; k < N; k++)
      chk($sformatf("rst_rsp%0d", k), 32'(rsp_o[k] != '0), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single requester, slave ready at once.
    issue(0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, 0, 0, 1, 1);
    gnt_q.push_back(0);
    @(negedge clk);
    #1;
    chk("n0_req_valid", 32'(req_o.valid), 0);
    @(posedge clk);
    #1;
    chk("n1_req_valid", 32'(req_o.valid), 1);
    chk("n1_req_addr", req_o.addr, 32'h0000_0010);
    chk("n1_req_wdata", req_o.wdata, 32'h1234_5678);
    chk("n1_req_write", 32'(req_o.write), 1);
    chk("n1_rsp0_ready", 32'(rsp_o[0].ready), 1);
    chk("n1_busy", 32'(busy_o), 1);
    @(posedge clk);
    #1;
    chk("n2_busy", 32'(busy_o), 0);

    // Reset while the slave stalls requester 2 (rr_ptr is 1).
    issue(2, 1'b0, 32'hFFFF_0000, 32'h0, 32'h0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("stall_busy", 32'(busy_o), 1);
    chk("stall_grant", 32'(grant_idx_o), 2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_req_valid", 32'(req_o.valid), 0);
    chk("mrst_busy", 32'(busy_o), 0);
    chk("mrst_grant", 32'(grant_idx_o), 0);
    for (int k = 0; k < N; k++)
      chk($sformatf("mrst_ready%0d", k), 32'(rsp_o[k].ready), 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention after reset: 0 then 1.
    issue(0, 1'b0, 32'h0000_0020, 32'h0, 32'h1000_0020, 0, 0, 1, 1);
    issue(1, 1'b1, 32'h0000_0024, 32'hCAFE_F00D, 32'h0, 0, 0, 1, 1);
    gnt_q.push_back(0);
    gnt_q.push_back(1);
    drain(40);

    // Wrap-around from rr_ptr=2, plus error routing to index 2.
    issue(0, 1'b0, 32'h0000_0030, 32'h0, 32'h1000_0030, 0, 0, 1, 1);
    issue(2, 1'b0, 32'h0000_0BAD, 32'h0, 32'h1000_0BAD, 1, 0, 1, 1);
    gnt_q.push_back(2);
    gnt_q.push_back(0);
    drain(40);

    // Fairness: slave answers on the 4th busy cycle, rr_ptr is 1.
    slv_lat = 3;
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b0, 32'h0000_0100 + 32'(8*i), 32'h0,
            32'h1000_0100 + 32'(8*i), 0, 0, 4, 1);
      issue(1, 1'b0, 32'h0000_0200 + 32'(8*i), 32'h0,
            32'h1000_0200 + 32'(8*i), 0, 0, 4, 1);
      gnt_q.push_back(1);
      gnt_q.push_back(0);
    end
    drain(200);
    slv_lat = 0;

`ifdef AO_ARB_TIMEOUT_EN
    // Requester 1 stalls into a timeout, then 0 gets the bus.
    issue(1, 1'b0, 32'hFFFF_0040, 32'h0, TIMEOUT_RDATA, 1, 1, TO, 1);
    issue(0, 1'b0, 32'h0000_0044, 32'h0, 32'h1000_0044, 0, 0, 1, 1);
    gnt_q.push_back(1);
    gnt_q.push_back(0);
    drain(60);
`endif

    chk("gnt_order_left", gnt_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
